// File: rtl/core_pkg.sv
// Shared writeback types: load funct3 encodings, datapath width and the request record.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            is_load;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
  } wb_req_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load alignment and sign/zero extension, with an illegal/misaligned flag.
module load_formatter
  import core_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_addr_lo +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (load_funct3_e'(i_funct3))
      LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LBU: o_data = {24'd0, w_byte};
      LH: begin
        o_data = {{16{w_half[15]}}, w_half};
        o_err  = i_addr_lo[0];
      end
      LHU: begin
        o_data = {16'd0, w_half};
        o_err  = i_addr_lo[0];
      end
      LW: begin
        o_data = i_rdata;
        o_err  = (i_addr_lo != 2'b00);
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU/LSU results, formats loads, writes the register file.
// Optional macro WB_BYPASS_EN adds combinational fwd_* outputs for decode forwarding.
module writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  output logic            rf_wr_en,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            load_err,
`ifdef WB_BYPASS_EN
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic [63:0]     instret
);

  import core_pkg::*;

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CntW-1:0] r_starve_cnt;
  logic            r_wr_en;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic            r_load_err;
  logic [63:0]     r_instret;

  wb_req_t         w_alu_req, w_lsu_req, w_req;
  logic            w_alu_win, w_xfer, w_fmt_err, w_err, w_wr;
  logic [XLEN-1:0] w_fmt_data, w_data;

  // LSU has priority unless the ALU has been stalled STARVE_MAX cycles in a row.
  always_comb begin
    w_alu_win = alu_valid && (!lsu_valid || (r_starve_cnt == CntW'(STARVE_MAX)));
    alu_ready = w_alu_win;
    lsu_ready = lsu_valid && !w_alu_win;
    w_xfer    = alu_valid || lsu_valid;
  end

  always_comb begin
    w_alu_req = '{rd: alu_rd, data: alu_result, is_load: 1'b0, funct3: 3'b000, addr_lo: 2'b00};
    w_lsu_req = '{rd: lsu_rd, data: lsu_rdata, is_load: 1'b1, funct3: lsu_funct3,
                  addr_lo: lsu_addr_lo};
    w_req     = w_alu_win ? w_alu_req : w_lsu_req;
  end

  load_formatter u_load_formatter (
    .i_funct3  (w_lsu_req.funct3),
    .i_addr_lo (w_lsu_req.addr_lo),
    .i_rdata   (w_lsu_req.data),
    .o_data    (w_fmt_data),
    .o_err     (w_fmt_err)
  );

  always_comb begin
    w_err  = w_req.is_load && w_fmt_err;
    w_data = w_req.is_load ? w_fmt_data : w_req.data;
    w_wr   = w_xfer && !w_err && (w_req.rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_wr_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_load_err   <= 1'b0;
      r_instret    <= '0;
    end else begin
      if (!alu_valid || alu_ready) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != CntW'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      r_wr_en    <= w_wr;
      r_load_err <= w_xfer && w_err;
      if (w_xfer && !w_err) begin
        r_rd_addr <= w_req.rd;
        r_rd_data <= w_data;
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_rd_addr = r_rd_addr;
  assign rf_rd_data = r_rd_data;
  assign load_err   = r_load_err;
  assign instret    = r_instret;

`ifdef WB_BYPASS_EN
  assign fwd_valid = w_wr;
  assign fwd_addr  = w_req.rd;
  assign fwd_data  = w_data;
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage; directly upstream of the register file write port.
- Two sources each offer one completed result per cycle on a valid/ready handshake: the ALU path and the load/store unit (LSU) load-response path.
- The block arbitrates between them, aligns and sign/zero-extends load data, and drives a registered write (wr_en/rd_addr/rd_data) into the register file.
- Also maintains the retired-instruction counter and flags illegal or misaligned load formats.

Parameters:
- XLEN, 32, datapath width; must be 32 (RV32).
- STARVE_MAX, 2, number of consecutive ALU stall cycles after which the ALU wins arbitration.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_result  in  XLEN  ALU result.
- lsu_valid  in  1  load response offered.
- lsu_ready  out  1  load response accepted this cycle.
- lsu_rd  in  5  load destination register.
- lsu_rdata  in  XLEN  raw aligned memory word.
- lsu_funct3  in  3  load type (RV32I funct3).
- lsu_addr_lo  in  2  byte offset (addr[1:0]).
- rf_wr_en  out  1  register-file write enable.
- rf_rd_addr  out  5  register-file write address.
- rf_rd_data  out  XLEN  register-file write data.
- load_err  out  1  one-cycle pulse: illegal or misaligned load.
- instret  out  64  retired-instruction count.

Behaviour:
- Reset values:
  - rf_wr_en=0, rf_rd_addr=0, rf_rd_data=0.
  - load_err=0, instret=0, starve counter=0.
  - Reset may assert mid-transfer; any in-flight write is dropped.
- Transfer rule: a transfer occurs when valid&&ready. The stage is never back-pressured downstream, so exactly one source transfers per cycle whenever either source is valid.
- Arbitration (combinational ready):
  - Default: LSU wins.
  - If starve_cnt==STARVE_MAX and alu_valid, the ALU wins instead.
  - Only the winner sees ready=1.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle alu_valid && !alu_ready.
  - Clears on an ALU transfer, or whenever alu_valid=0.
- Latency: a transfer in cycle N produces the register-file write in cycle N+1; rf_* outputs are registered.
- rd=0 handling: the transfer is accepted and counted in instret, but rf_wr_en stays 0.
- Load formatting (LSU path):
  - LB(000): byte at lsu_addr_lo, sign-extended.
  - LBU(100): byte at lsu_addr_lo, zero-extended.
  - LH(001)/LHU(101): halfword at lsu_addr_lo[1], sign-extended for LH, zero-extended for LHU.
  - LW(010): full word.
- Load errors:
  - Conditions: LH/LHU with lsu_addr_lo[0]=1; LW with lsu_addr_lo!=0; funct3 in {011,110,111}.
  - Effect in cycle N+1: load_err=1, rf_wr_en=0, instret not incremented. The transfer is still consumed.
- instret:
  - Increments by 1 in cycle N+1 for every non-error transfer.
  - 64-bit, wraps from all-ones to 0.
- Idle cycles: rf_wr_en=0; rf_rd_addr and rf_rd_data hold their last values.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds three outputs, fwd_valid(1), fwd_addr(5) and fwd_data(XLEN).
  - They are a combinational copy of the winning transfer's formatted result in cycle N, for decode-stage operand forwarding.
  - fwd_valid=0 for rd=0 and for erroring loads.
- Undefined: the ports do not exist; decode relies on the one-cycle-later register-file write.

Decomposition:
- Shared package (core_pkg):
  - load funct3 enum: LB, LH, LW, LBU, LHU.
  - XLEN constant.
  - wb_req_t struct: rd, data, is_load, funct3, addr_lo.
- Sub-module load_formatter: combinational. Inputs are funct3, addr_lo and rdata; outputs are the formatted data and an err flag. It is reused by any future LSU bypass path.

Test Plan:
- ALU only: alu_valid=1, rd=5, result=0xDEADBEEF in cycle 0 → cycle 1: rf_wr_en=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF; instret=1.
- LB sign-extend: lsu_rdata=0x12_80_34_56, addr_lo=2, funct3=000, rd=7 → rf_rd_data=0xFFFFFF80. Same stimulus with LBU → 0x00000080.
- Misaligned LW: addr_lo=1, funct3=010 → load_err pulse 1 cycle, rf_wr_en=0, instret unchanged, lsu_ready=1.
- Contention and starvation: alu_valid and lsu_valid held high for 6 cycles with STARVE_MAX=2 → grant order L,L,A,L,L,A; no transfer lost or duplicated.
- rd=0: ALU transfer to x0 → rf_wr_en=0, instret increments.
- Reset mid-stream: assert rst_n=0 while a transfer is in flight → all outputs zero immediately; after release, the first write appears one cycle after the first transfer.
